// File: rtl/sram_pkg.sv
// Shared definitions for the external 16-bit asynchronous SRAM pin interface.
package sram_pkg;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;

  // Byte-lane indices into a two-bit lane-enable vector.
  localparam int LANE_LO = 0;
  localparam int LANE_HI = 1;

  // One slot of the read-return pipeline.
  typedef struct packed {
    logic        valid;
    logic [15:0] data;
    logic [1:0]  lane_en;
  } sram_rd_stage_t;

endpackage

// File: rtl/sram_read_pipe.sv
// Fixed-latency read-return pipeline. It always shifts and never stalls.
// READ_LAT=0 passes the capture stage straight through, which gives an
// asynchronous read.
module sram_read_pipe
  import sram_pkg::*;
#(
  parameter int READ_LAT = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  sram_rd_stage_t stage_i,
  output sram_rd_stage_t stage_o
);

  if (READ_LAT == 0) begin : g_bypass
    // There are no flops in this case, so clk and rst are deliberately unused.
    logic unused_clk_rst;
    assign unused_clk_rst = clk | rst;
    assign stage_o        = stage_i;
  end else begin : g_pipe
    sram_rd_stage_t pipe_q [READ_LAT];

    // Shift register. An asynchronous reset flushes every in-flight read.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < READ_LAT; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= stage_i;
        for (int i = 1; i < READ_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign stage_o = pipe_q[READ_LAT-1];
  end

endmodule

// File: rtl/sram_device_responder.sv
// Device-side model of an IS61LV25616-style asynchronous SRAM.
// It provides a byte-lane write path, a fixed-latency read path and
// saturating counters of accepted accesses.
//
// Bus handshake: a write is accepted at a posedge when CE_N=0 and WE_N=0.
// A read is accepted when CE_N=0, WE_N=1 and OE_N=0. Neither kind of access
// can stall. DQ is driven only while a read cycle is open and a valid result
// sits at the pipeline output. WE_N=0 therefore always releases the bus.
module sram_device_responder
  import sram_pkg::*;
#(
  parameter int    ADDR_W     = SRAM_ADDR_W,
  parameter int    DATA_W     = SRAM_DATA_W,  // must be 16: two byte lanes
  parameter int    DEPTH_LOG2 = 18,
  parameter int    READ_LAT   = 0,            // 0..3
  parameter string INIT_FILE  = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  input  logic              SRAM_UB_N,
  input  logic              SRAM_LB_N,
  input  logic              SRAM_WE_N,
  input  logic              SRAM_CE_N,
  input  logic              SRAM_OE_N,
  output logic [15:0]       wr_count,
  output logic [15:0]       rd_count
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  drive_en;
  logic [15:0]           wr_count_q, wr_count_d;
  logic [15:0]           rd_count_q, rd_count_d;
  sram_rd_stage_t        cap_stage;
  sram_rd_stage_t        out_stage;

  // Address bits above the array depth alias the lower words.
  assign idx    = SRAM_ADDR[DEPTH_LOG2-1:0];
  assign wr_acc = ~SRAM_CE_N & ~SRAM_WE_N;
  assign rd_acc = ~SRAM_CE_N &  SRAM_WE_N & ~SRAM_OE_N;

  // Byte-lane writes. The memory is never cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      if (!SRAM_LB_N) mem_q[idx][7:0]  <= SRAM_DQ[7:0];
      if (!SRAM_UB_N) mem_q[idx][15:8] <= SRAM_DQ[15:8];
    end
  end

  // Read capture: the data word together with the lane enables in force at the sample edge.
  always_comb begin
    cap_stage                  = '0;
    cap_stage.valid            = rd_acc;
    cap_stage.data             = mem_q[idx];
    cap_stage.lane_en[LANE_HI] = ~SRAM_UB_N;
    cap_stage.lane_en[LANE_LO] = ~SRAM_LB_N;
  end

  sram_read_pipe #(
    .READ_LAT (READ_LAT)
  ) u_read_pipe (
    .clk     (clk),
    .rst     (rst),
    .stage_i (cap_stage),
    .stage_o (out_stage)
  );

  // The current cycle must also be a read cycle, so a result that arrives
  // during a write or with CE_N=1 is dropped.
  assign drive_en = ~rst & rd_acc & out_stage.valid;

  assign SRAM_DQ[15:8] = (drive_en & out_stage.lane_en[LANE_HI]) ? out_stage.data[15:8] : 8'hzz;
  assign SRAM_DQ[7:0]  = (drive_en & out_stage.lane_en[LANE_LO]) ? out_stage.data[7:0]  : 8'hzz;

  // Saturating next-state logic for the access counters.
  always_comb begin
    wr_count_d = wr_count_q;
    rd_count_d = rd_count_q;
    if (wr_acc && (wr_count_q != 16'hFFFF)) wr_count_d = wr_count_q + 16'd1;
    if (rd_acc && (rd_count_q != 16'hFFFF)) rd_count_d = rd_count_q + 16'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_count_q <= '0;
      rd_count_q <= '0;
    end else begin
      wr_count_q <= wr_count_d;
      rd_count_q <= rd_count_d;
    end
  end

  assign wr_count = wr_count_q;
  assign rd_count = rd_count_q;

endmodule

// File: tb/tb_sram_device_responder.sv
// Bench for sram_device_responder. u_dut0 runs with READ_LAT=0 and full
// depth. u_dut1 runs with READ_LAT=2 and DEPTH_LOG2=8 (address aliasing).
// Both DQ buses have pull-ups, so an undriven byte lane reads as 8'hFF.
module tb_sram_device_responder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rst1;
  logic [17:0] addr0, addr1;
  logic        ub0_n, lb0_n, we0_n, ce0_n, oe0_n;
  logic        ub1_n, lb1_n, we1_n, ce1_n, oe1_n;
  logic        tb0_en, tb1_en;
  logic [15:0] tb0_d, tb1_d;
  wire  [15:0] dq0, dq1;
  wire  [15:0] wr0, rd0, wr1, rd1;

  assign dq0 = tb0_en ? tb0_d : 16'hzzzz;
  assign dq1 = tb1_en ? tb1_d : 16'hzzzz;

  for (genvar g = 0; g < 16; g++) begin : g_pu
    pullup (dq0[g]);
    pullup (dq1[g]);
  end

  sram_device_responder #(
    .ADDR_W(18), .DATA_W(16), .DEPTH_LOG2(18), .READ_LAT(0), .INIT_FILE("")
  ) u_dut0 (
    .clk(clk), .rst(rst0), .SRAM_ADDR(addr0), .SRAM_DQ(dq0),
    .SRAM_UB_N(ub0_n), .SRAM_LB_N(lb0_n), .SRAM_WE_N(we0_n),
    .SRAM_CE_N(ce0_n), .SRAM_OE_N(oe0_n), .wr_count(wr0), .rd_count(rd0)
  );

  sram_device_responder #(
    .ADDR_W(18), .DATA_W(16), .DEPTH_LOG2(8), .READ_LAT(2), .INIT_FILE("")
  ) u_dut1 (
    .clk(clk), .rst(rst1), .SRAM_ADDR(addr1), .SRAM_DQ(dq1),
    .SRAM_UB_N(ub1_n), .SRAM_LB_N(lb1_n), .SRAM_WE_N(we1_n),
    .SRAM_CE_N(ce1_n), .SRAM_OE_N(oe1_n), .wr_count(wr1), .rd_count(rd1)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic ce, we, oe, ub, lb, input logic [17:0] a, input logic [15:0] d);
    ce0_n = ce; we0_n = we; oe0_n = oe; ub0_n = ub; lb0_n = lb;
    addr0 = a; tb0_d = d; tb0_en = ~we;
  endtask

  task automatic drive1(input logic ce, we, oe, ub, lb, input logic [17:0] a, input logic [15:0] d);
    ce1_n = ce; we1_n = we; oe1_n = oe; ub1_n = ub; lb1_n = lb;
    addr1 = a; tb1_d = d; tb1_en = ~we;
  endtask

  // One READ_LAT=2 cycle: drive the inputs, check DQ mid-cycle, then advance.
  task automatic cyc1(input string nm, input logic ce, we, oe, ub, lb,
                      input logic [17:0] a, input logic [15:0] d, input logic [15:0] exp);
    drive1(ce, we, oe, ub, lb, a, d);
    @(negedge clk);
    check(nm, dq1, exp);
    next_cycle();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        ce_n, we_n, oe_n, ub_n, lb_n;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_dq;
    logic [15:0] exp_wr;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input logic ce, we, oe, ub, lb, input logic [17:0] a,
                         input logic [15:0] d, input logic [15:0] edq, ewr, erd);
    vec_t v;
    v.ce_n = ce; v.we_n = we; v.oe_n = oe; v.ub_n = ub; v.lb_n = lb;
    v.addr = a; v.wdata = d; v.exp_dq = edq; v.exp_wr = ewr; v.exp_rd = erd;
    vq.push_back(v);
  endtask

  logic [15:0] load_lo, load_hi;

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    drive0(1, 1, 1, 1, 1, 18'h0, 16'h0);
    drive1(1, 1, 1, 1, 1, 18'h0, 16'h0);
    load_lo = '0; load_hi = '0;

    // Counts give the values seen mid-cycle, before that cycle's closing edge.
    //       ce we oe ub lb  addr      wdata     exp_dq    wr  rd
    add_vec(0, 0, 1, 0, 0, 18'h10,  16'hBEEF, 16'hBEEF, 0, 0);
    add_vec(0, 1, 0, 0, 0, 18'h10,  16'h0000, 16'hBEEF, 1, 0);
    add_vec(1, 1, 1, 1, 1, 18'h0,   16'h0000, 16'hFFFF, 1, 1);
    add_vec(0, 0, 1, 0, 0, 18'h5,   16'h1234, 16'h1234, 1, 1);
    add_vec(0, 0, 1, 1, 0, 18'h5,   16'hABCD, 16'hABCD, 2, 1);
    add_vec(0, 1, 0, 0, 1, 18'h5,   16'h0000, 16'h12FF, 3, 1);
    add_vec(0, 1, 0, 0, 0, 18'h5,   16'h0000, 16'h12CD, 3, 2);
    add_vec(0, 0, 1, 0, 0, 18'h100, 16'hBEEF, 16'hBEEF, 3, 3);
    add_vec(0, 0, 1, 0, 0, 18'h101, 16'hDEAD, 16'hDEAD, 4, 3);
    add_vec(0, 1, 0, 0, 0, 18'h100, 16'h0000, 16'hBEEF, 5, 3);
    add_vec(0, 1, 0, 0, 0, 18'h101, 16'h0000, 16'hDEAD, 5, 4);
    add_vec(1, 0, 0, 0, 0, 18'h5,   16'h0101, 16'h0101, 5, 5);
    add_vec(0, 1, 0, 0, 0, 18'h5,   16'h0000, 16'h12CD, 5, 5);
    add_vec(0, 0, 1, 1, 1, 18'h5,   16'h7777, 16'h7777, 5, 6);
    add_vec(0, 1, 0, 0, 0, 18'h5,   16'h0000, 16'h12CD, 6, 6);
    add_vec(0, 0, 0, 1, 0, 18'h10,  16'h0011, 16'h0011, 6, 7);
    add_vec(0, 1, 0, 0, 0, 18'h10,  16'h0000, 16'hBE11, 7, 7);
    add_vec(0, 1, 1, 0, 0, 18'h10,  16'h0000, 16'hFFFF, 7, 8);
    add_vec(1, 1, 1, 1, 1, 18'h0,   16'h0000, 16'hFFFF, 7, 8);

    // Reset state.
    #3;
    check("rst_dq0", dq0, 16'hFFFF);
    check("rst_dq1", dq1, 16'hFFFF);
    check("rst_wr0", wr0, 16'h0);
    check("rst_rd0", rd0, 16'h0);
    check("rst_wr1", wr1, 16'h0);
    check("rst_rd1", rd1, 16'h0);
    next_cycle();
    rst0 = 1'b0; rst1 = 1'b0;

    // READ_LAT=0 table.
    for (int i = 0; i < vq.size(); i++) begin
      drive0(vq[i].ce_n, vq[i].we_n, vq[i].oe_n, vq[i].ub_n, vq[i].lb_n, vq[i].addr, vq[i].wdata);
      @(negedge clk);
      check($sformatf("vec%0d_dq", i), dq0, vq[i].exp_dq);
      check($sformatf("vec%0d_wr", i), wr0, vq[i].exp_wr);
      check($sformatf("vec%0d_rd", i), rd0, vq[i].exp_rd);
      if (i == 9)  load_lo = dq0;
      if (i == 10) load_hi = dq0;
      next_cycle();
    end
    check("load32", {load_hi, load_lo}, 32'hDEADBEEF);

    // Saturating read counter.
    force u_dut0.rd_count_q = 16'hFFFE;
    #1;
    release u_dut0.rd_count_q;
    @(negedge clk);
    check("sat_preload", rd0, 16'hFFFE);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      drive0(0, 1, 0, 0, 0, 18'h10, 16'h0);
      next_cycle();
      @(negedge clk);
      check($sformatf("sat_rd%0d", i), rd0, 16'hFFFF);
      #1;
    end

    // CE_N=1 with WE_N=0 has no effect.
    drive0(1, 0, 1, 0, 0, 18'h10, 16'h5555);
    next_cycle();
    drive0(0, 1, 0, 0, 0, 18'h10, 16'h0);
    @(negedge clk);
    check("ce_off_mem", dq0, 16'hBE11);
    check("ce_off_wr", wr0, 16'd7);
    next_cycle();
    drive0(1, 1, 1, 1, 1, 18'h0, 16'h0);

    // READ_LAT=2: write through the alias 0x107 -> word 7, then latency and lane checks.
    cyc1("l2_wr_alias",  0, 0, 1, 0, 0, 18'h107, 16'h0042, 16'h0042);
    cyc1("l2_rdA_z",     0, 1, 0, 0, 0, 18'h7,   16'h0,    16'hFFFF);
    cyc1("l2_rdB_z",     0, 1, 0, 1, 1, 18'h7,   16'h0,    16'hFFFF);
    cyc1("l2_A_data",    0, 1, 0, 1, 1, 18'h7,   16'h0,    16'h0042);
    cyc1("l2_B_masked",  0, 1, 0, 0, 0, 18'h7,   16'h0,    16'hFFFF);
    cyc1("l2_ce_off",    1, 1, 1, 0, 0, 18'h7,   16'h0,    16'hFFFF);
    cyc1("l2_we_discard",0, 0, 1, 1, 1, 18'h7,   16'h5A5A, 16'h5A5A);
    cyc1("l2_empty0",    0, 1, 0, 0, 0, 18'h8,   16'h0,    16'hFFFF);
    cyc1("l2_empty1",    0, 1, 0, 1, 1, 18'h8,   16'h0,    16'hFFFF);
    drive1(1, 1, 1, 1, 1, 18'h0, 16'h0);
    @(negedge clk);
    check("l2_wr_cnt", wr1, 16'd2);
    check("l2_rd_cnt", rd1, 16'd6);
    next_cycle();

    // A read captured before a write returns the old data.
    cyc1("l2_old_rd",    0, 1, 0, 0, 0, 18'h7,   16'h0,    16'hFFFF);
    cyc1("l2_old_wr",    0, 0, 1, 0, 0, 18'h7,   16'h1357, 16'h1357);
    cyc1("l2_old_data",  0, 1, 0, 1, 1, 18'h8,   16'h0,    16'h0042);
    cyc1("l2_after_wr",  0, 1, 0, 0, 0, 18'h7,   16'h0,    16'hFFFF);
    cyc1("l2_masked2",   0, 1, 0, 0, 0, 18'h7,   16'h0,    16'hFFFF);
    cyc1("l2_new_data",  0, 1, 0, 0, 0, 18'h7,   16'h0,    16'h1357);
    cyc1("l2_new_data2", 0, 1, 0, 0, 0, 18'h7,   16'h0,    16'h1357);

    // Reset one cycle after a read sample.
    drive1(0, 1, 0, 0, 0, 18'h7, 16'h0);
    #1;
    check("l2_pre_rst", dq1, 16'h1357);
    rst1 = 1'b1;
    #1;
    check("l2_rst_z", dq1, 16'hFFFF);
    check("l2_rst_rd", rd1, 16'h0);
    check("l2_rst_wr", wr1, 16'h0);
    @(negedge clk);
    check("l2_rst_z_mid", dq1, 16'hFFFF);
    next_cycle();
    rst1 = 1'b0;
    cyc1("l2_flushed",   0, 1, 0, 0, 0, 18'h7,   16'h0,    16'hFFFF);
    cyc1("l2_post_rst1", 0, 1, 0, 1, 1, 18'h7,   16'h0,    16'hFFFF);
    cyc1("l2_reread",    0, 1, 0, 0, 0, 18'h9,   16'h0,    16'h1357);
    drive1(1, 1, 1, 1, 1, 18'h0, 16'h0);
    @(negedge clk);
    check("l2_post_rd_cnt", rd1, 16'd3);
    check("l2_post_wr_cnt", wr1, 16'd0);
    next_cycle();

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
